// File: rtl/random_access_memory.sv
// 16 x 8-bit program/data memory with a post-reset clear sequencer, CPU bus
// write/read port and front-panel (manual) programming port.
module random_access_memory (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] address,
    input  logic       write_from_bus,
    input  logic       output_to_bus,
    input  logic       manual_mode,
    input  logic       manual_write,
    input  logic [7:0] manual_data,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_out_en,
    output logic [7:0] contents,
    output logic       init_busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] clear_ptr_q, clear_ptr_d;
    logic       btn_prev_q, btn_prev_d;
    logic [7:0] mem_q [16];

    logic       btn_rise;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        btn_prev_d  = manual_write;
        btn_rise    = manual_write && !btn_prev_q;
        mem_we      = 1'b0;
        mem_waddr   = address;
        mem_wdata   = bus_in;

        case (state_q)
            CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = clear_ptr_q;
                mem_wdata   = 8'h00;
                clear_ptr_d = clear_ptr_q + 4'd1;
                if (clear_ptr_q == 4'hF) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (manual_mode) begin
                    if (btn_rise) begin
                        mem_we    = 1'b1;
                        mem_wdata = manual_data;
                    end
                end else if (write_from_bus) begin
                    mem_we = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clear_ptr_q <= 4'd0;
            btn_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            btn_prev_q  <= btn_prev_d;
        end
    end

    // NOTE: the array itself has no reset; the clear sequencer zeroes it, keeping it RAM-inferable.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign init_busy  = (state_q == CLEAR);
    assign bus_out_en = (state_q == RUN) && !manual_mode && output_to_bus;
    assign contents   = mem_q[address];
    assign bus_out    = bus_out_en ? mem_q[address] : 8'h00;

endmodule

// File: tb/tb_random_access_memory.sv
// Scoreboard bench for random_access_memory: the driver pushes expected outputs
// from an abstract model, and a monitor pops and compares them on the falling edge.
module tb_random_access_memory;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] address;
    logic       write_from_bus;
    logic       output_to_bus;
    logic       manual_mode;
    logic       manual_write;
    logic [7:0] manual_data;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_out_en;
    logic [7:0] contents;
    logic       init_busy;

    always #5 clk = ~clk;

    random_access_memory dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .write_from_bus (write_from_bus),
        .output_to_bus  (output_to_bus),
        .manual_mode    (manual_mode),
        .manual_write   (manual_write),
        .manual_data    (manual_data),
        .bus_in         (bus_in),
        .bus_out        (bus_out),
        .bus_out_en     (bus_out_en),
        .contents       (contents),
        .init_busy      (init_busy)
    );

    typedef struct {
        string      tag;
        bit         chk_contents;
        logic [7:0] contents;
        logic [7:0] bus_out;
        logic       bus_out_en;
        logic       init_busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: memory image, which locations hold defined data,
    // how many clear steps remain, and the last seen button level.
    logic [7:0] ref_mem [16];
    bit         known   [16];
    int         clear_left;
    bit         btn_prev_m;
    string      cur_tag;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
    task automatic step(input bit r, input logic [3:0] a, input bit wfb, input bit otb,
                        input bit mm, input bit mw, input logic [7:0] md, input logic [7:0] bi);
        exp_t e;
        rst            = r;
        address        = a;
        write_from_bus = wfb;
        output_to_bus  = otb;
        manual_mode    = mm;
        manual_write   = mw;
        manual_data    = md;
        bus_in         = bi;

        e.tag          = cur_tag;
        e.init_busy    = (clear_left > 0);
        e.bus_out_en   = !e.init_busy && !mm && otb;
        e.chk_contents = known[a];
        e.contents     = ref_mem[a];
        e.bus_out      = e.bus_out_en ? ref_mem[a] : 8'h00;
        exp_q.push_back(e);

        if (r) begin
            clear_left = 16;
            btn_prev_m = 1'b1;
        end else if (clear_left > 0) begin
            ref_mem[16 - clear_left] = 8'h00;
            known[16 - clear_left]   = 1'b1;
            clear_left--;
            btn_prev_m = mw;
        end else begin
            if (!mm && wfb) begin
                ref_mem[a] = bi;
                known[a]   = 1'b1;
            end else if (mm && mw && !btn_prev_m) begin
                ref_mem[a] = md;
                known[a]   = 1'b1;
            end
            btn_prev_m = mw;
        end

        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".init_busy"}, {7'd0, init_busy}, {7'd0, e.init_busy});
                check({e.tag, ".bus_out_en"}, {7'd0, bus_out_en}, {7'd0, e.bus_out_en});
                check({e.tag, ".bus_out"}, bus_out, e.bus_out);
                if (e.chk_contents) begin
                    check({e.tag, ".contents"}, contents, e.contents);
                end
            end
        end
    end

    initial begin : driver
        bit mw_r;

        rst            = 1'b1;
        address        = 4'd0;
        write_from_bus = 1'b0;
        output_to_bus  = 1'b0;
        manual_mode    = 1'b0;
        manual_write   = 1'b0;
        manual_data    = 8'h00;
        bus_in         = 8'h00;
        @(posedge clk);
        #1;
        clear_left = 16;
        btn_prev_m = 1'b1;
        for (int i = 0; i < 16; i++) begin
            known[i]   = 1'b0;
            ref_mem[i] = 8'h00;
        end

        cur_tag = "clear0";
        for (int i = 0; i < 16; i++) step(0, 4'(i), 0, 1, 0, 0, 8'h00, 8'h00);

        cur_tag = "preload";
        for (int i = 0; i < 16; i++) step(0, 4'(i), 1, 0, 0, 0, 8'h00, 8'hFF);

        cur_tag = "rst_pulse";
        step(1, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00);
        cur_tag = "clear1";
        for (int i = 0; i < 16; i++) step(0, 4'hF, 0, 1, 0, 0, 8'h00, 8'h00);
        cur_tag = "sweep";
        for (int i = 0; i < 16; i++) step(0, 4'(i), 0, 1, 0, 0, 8'h00, 8'h00);

        cur_tag = "bus_wr";
        step(0, 4'h5, 1, 0, 0, 0, 8'h00, 8'hA7);
        cur_tag = "bus_rd";
        step(0, 4'h5, 0, 1, 0, 0, 8'h00, 8'h00);
        cur_tag = "bus_idle";
        step(0, 4'h5, 0, 0, 0, 0, 8'h00, 8'h00);

        cur_tag = "man_hold";
        for (int k = 0; k < 5; k++) step(0, 4'hF, 0, 0, 1, 1, (k < 2) ? 8'h3C : 8'h11, 8'h00);
        cur_tag = "man_rel";
        step(0, 4'hF, 0, 0, 1, 0, 8'h11, 8'h00);
        cur_tag = "man_press2";
        step(0, 4'hF, 0, 0, 1, 1, 8'h11, 8'h00);
        step(0, 4'hF, 0, 0, 1, 0, 8'h11, 8'h00);

        cur_tag = "gate_bus";
        step(0, 4'h3, 1, 1, 1, 0, 8'h00, 8'h99);
        step(0, 4'h3, 0, 1, 0, 0, 8'h00, 8'h00);
        cur_tag = "gate_btn";
        step(0, 4'h4, 0, 0, 0, 0, 8'h55, 8'h00);
        step(0, 4'h4, 0, 0, 0, 1, 8'h55, 8'h00);
        step(0, 4'h4, 0, 0, 1, 1, 8'h55, 8'h00);
        step(0, 4'h4, 0, 0, 1, 0, 8'h55, 8'h00);

        cur_tag = "simul";
        step(0, 4'h2, 1, 0, 0, 0, 8'h00, 8'h10);
        step(0, 4'h2, 1, 1, 0, 0, 8'h00, 8'h20);
        step(0, 4'h2, 0, 1, 0, 0, 8'h00, 8'h00);

        cur_tag = "mid_rst";
        step(1, 4'h9, 0, 0, 0, 1, 8'h77, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 4'h9, 1, 1, 0, 1, 8'h77, 8'hEE);
        step(1, 4'h9, 1, 0, 0, 1, 8'h77, 8'hEE);
        cur_tag = "reclear";
        for (int i = 0; i < 16; i++) step(0, 4'h9, 1, 1, 1, 1, 8'h77, 8'hEE);
        cur_tag = "held_btn";
        for (int i = 0; i < 3; i++) step(0, 4'h6, 0, 0, 1, 1, 8'h77, 8'h00);
        cur_tag = "sweep2";
        for (int i = 0; i < 16; i++) step(0, 4'(i), 0, 1, 0, 1, 8'h00, 8'h00);

        cur_tag = "random";
        mw_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) mw_r = ~mw_r;
            step($urandom_range(0, 99) == 0, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), mw_r,
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drain", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
